mem_initiator: RTL and testbench
================================

# mem_initiator

Bus initiator for the single-port `memory` block, driving the same `wr_en`/`addr`/`data` signal set that the memory samples. Upstream logic issues one read or write command per valid/ready handshake. The block sequences the memory-side signals, samples read data after a fixed read latency and returns one response per command. It is the active end of the memory interface: synthesizable logic now drives what the bench driver used to drive.

## Interface
- `AW`, 8, address width
- `DW`, 8, data width
- `RD_LAT`, 1, cycles from read address presented to `mem_rdata` valid; legal 1..4
- `clk` in 1: sole clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `req_valid` in 1: command valid
- `req_ready` out 1: command accepted when both high
- `req_wr` in 1: 1 = write, 0 = read
- `req_addr` in AW: command address
- `req_wdata` in DW: write data
- `rsp_valid` out 1: response valid
- `rsp_ready` in 1: response consumed when both high
- `rsp_rdata` out DW: read data (0 for plain writes)
- `rsp_err` out 1: readback mismatch (see Configuration)
- `txn_cnt` out 16: completed-transaction counter
- `mem_wr_en` out 1: memory write strobe
- `mem_addr` out AW: memory address
- `mem_wdata` out DW: memory write data
- `mem_rdata` in DW: memory read data

## Operation
- FSM states: IDLE, WR, RD, RD_WAIT, RESP. Reset state: IDLE.
- IDLE:
  - `req_ready`=1.
  - On handshake, capture `req_wr`, `req_addr`, `req_wdata`.
  - Go to WR if `req_wr`=1, else RD.
- WR:
  - `mem_wr_en`=1 for exactly one cycle, with the captured `mem_addr` and `mem_wdata`.
  - Next state: RESP, or RD when the verify feature is compiled in.
- RD:
  - `mem_wr_en`=0; `mem_addr`=captured address.
  - Load wait counter with `RD_LAT`-1, then go to RD_WAIT.
  - If `RD_LAT`=1, go straight to the sample cycle.
- RD_WAIT:
  - Decrement the counter each cycle; `mem_addr` is held.
  - On the cycle `RD_LAT` after RD, register `mem_rdata` into `rsp_rdata`, then go to RESP.
- RESP:
  - `rsp_valid`=1. `rsp_rdata` and `rsp_err` are held stable until `rsp_ready`=1.
  - On handshake: `txn_cnt`+1 (wraps 0xFFFF to 0), then IDLE.
- `req_ready`=0 in every state except IDLE. `req_valid` outside IDLE is ignored; no command is queued.
- All memory-side outputs are registered. Outside WR/RD, `mem_addr` and `mem_wdata` hold their last values and `mem_wr_en`=0.

## Timing
- All outputs reset to 0: `req_ready` and `rsp_*` low, `mem_*` zero, `txn_cnt`=0. Reset clears on assertion with no clock required.
- Latencies, with C = accept cycle:
  - Write: `mem_wr_en` high in C+1; `rsp_valid` from C+2.
  - Read: `mem_addr` valid from C+1; `mem_rdata` sampled at the end of C+`RD_LAT`+1; `rsp_valid` from C+`RD_LAT`+2.
- Minimum spacing between accepts: write 3 cycles, read `RD_LAT`+3 cycles, with `rsp_ready` held high.
- Reset asserted mid-transaction:
  - The transaction is dropped with no response.
  - `mem_wr_en` falls asynchronously.
  - `req_ready`=1 in the first clock cycle after release.
- Simultaneous `rsp_ready` and `req_valid` in RESP: the response completes. The new command is accepted only in the following IDLE cycle.

## Configuration
- Macro: `MEM_INIT_VERIFY_EN`.
- Defined:
  - Every write is followed by an automatic read of the same address (WR→RD→RD_WAIT→RESP).
  - `rsp_rdata` carries the readback value.
  - `rsp_err` = (readback != written data).
  - Write latency becomes `rsp_valid` from C+`RD_LAT`+3.
- Undefined:
  - Writes go WR→RESP.
  - `rsp_rdata`=0 on writes.
  - `rsp_err` is tied 0.

## Test plan
- Reset: drive `rst`=0 in the middle of an active write → `mem_wr_en`, `rsp_valid` and `txn_cnt` are 0 at once. After release, `req_ready`=1 within one clock.
- Write addr 0x02, data 0xA5 (macro off) → `mem_wr_en`=1 for one cycle at C+1 with `mem_addr`=0x02, `mem_wdata`=0xA5. `rsp_valid` at C+2, `rsp_rdata`=0. `txn_cnt`=1 after the handshake.
- Read addr 0x02 with `RD_LAT`=2, memory model holding 0xA5 → `mem_wr_en` stays 0. `rsp_valid` at C+4 with `rsp_rdata`=0xA5.
- Backpressure: hold `rsp_ready`=0 for 5 cycles while pulsing `req_valid` → `rsp_valid`/`rsp_rdata` stay stable, `req_ready`=0, and no extra memory activity occurs.
- Verify (macro on): write 0xA5 to 0x10 with the model corrupting readback to 0x5A → `rsp_err`=1, `rsp_rdata`=0x5A. The same write to a clean address gives `rsp_err`=0.
- Counter wrap: preload via 65535 transactions, or force the count to 0xFFFF, then complete one more → `txn_cnt`=0x0000.

Source files
------------

// File: rtl/mem_initiator.sv
// mem_initiator
//   Active initiator for the single-port memory. Takes one read/write command
//   per req handshake, drives the memory-side strobe, address and data, samples
//   read data RD_LAT cycles after the address, and returns one response per
//   command.
//
//   Optional feature (macro MEM_INIT_VERIFY_EN): every write is followed by an
//   automatic readback of the same address. rsp_rdata carries the readback and
//   rsp_err flags a mismatch. Without the macro, writes respond with rdata=0 and
//   rsp_err is tied low.
//
//   Ports
//     clk, rst         : clock (rising edge), async active-low reset
//     req_*            : command channel (valid/ready, wr, addr, wdata)
//     rsp_*            : response channel (valid/ready, rdata, err)
//     txn_cnt          : completed-transaction counter, wraps at 16 bits
//     mem_wr_en/addr/wdata : registered memory-side outputs
//     mem_rdata        : memory read data, valid RD_LAT cycles after the address
module mem_initiator #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int RD_LAT = 1    // legal 1..4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic [15:0]   txn_cnt,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  // Wait counter only ever holds RD_LAT-1 (0..3).
  localparam int CW = 2;

  typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, RESP} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic           accept;
  logic           rsp_hs;
  logic           sample;
  logic           req_ready_nxt;
  logic           mem_wr_en_nxt;

  assign accept = req_valid & req_ready;
  assign rsp_hs = rsp_valid & rsp_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = req_wr ? WR : RD;
`ifdef MEM_INIT_VERIFY_EN
      WR:      state_nxt = RD;
`else
      WR:      state_nxt = RESP;
`endif
      RD:      state_nxt = RD_WAIT;
      // cnt==0 marks the sample cycle; with RD_LAT=1 the first RD_WAIT cycle
      // is already the sample cycle.
      RD_WAIT: if (cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. req_ready and mem_wr_en are registered, so they are derived
  // from the next state; rsp_valid comes straight from the state register.
  // ---------------------------------------------------------------------------
  always_comb begin
    rsp_valid     = (state == RESP);
    sample        = (state == RD_WAIT) && (cnt == '0);
    req_ready_nxt = (state_nxt == IDLE);
    mem_wr_en_nxt = (state_nxt == WR);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers. Reset drops mem_wr_en immediately, abandoning any
  // in-flight write. req_ready stays low during reset and rises on the first
  // clock after release.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ready <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_rdata <= '0;
      cnt       <= '0;
      txn_cnt   <= '0;
    end else begin
      req_ready <= req_ready_nxt;
      mem_wr_en <= mem_wr_en_nxt;

      // Capture directly into the memory-side registers; they then hold
      // through the rest of the transaction and afterwards.
      if (accept) begin
        mem_addr  <= req_addr;
        rsp_rdata <= '0;
        if (req_wr) mem_wdata <= req_wdata;
      end

      if (state == RD)
        cnt <= CW'(RD_LAT - 1);
      else if (state == RD_WAIT && cnt != '0)
        cnt <= cnt - CW'(1);

      if (sample) rsp_rdata <= mem_rdata;

      if (rsp_hs) txn_cnt <= txn_cnt + 16'd1;
    end
  end

`ifdef MEM_INIT_VERIFY_EN
  // Remember whether the transaction was a write so the readback of a write
  // is compared against the data just written; plain reads never flag.
  logic is_wr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_wr   <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      if (accept) begin
        is_wr   <= req_wr;
        rsp_err <= 1'b0;
      end
      if (sample) rsp_err <= is_wr && (mem_rdata != mem_wdata);
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_initiator.sv
module tb_mem_initiator;

  localparam int RLAT = 2;
`ifdef MEM_INIT_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [15:0] txn_cnt;
  logic        mem_wr_en;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [15:0] exp_cnt = '0;

  mem_initiator #(.AW(8), .DW(8), .RD_LAT(RLAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .txn_cnt(txn_cnt),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Memory model: write on strobe, read data valid RLAT cycles after address.
  // cmask corrupts readback of selected addresses.
  // ---------------------------------------------------------------------------
  logic [7:0] mem_arr [256];
  logic [7:0] ref_mem [256];
  logic [7:0] cmask   [256];
  logic [7:0] ap      [RLAT];
  logic       mem_init = 1'b0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= ref_mem[i];
    end else if (mem_wr_en) begin
      mem_arr[mem_addr] <= mem_wdata;
    end
    ap[0] <= mem_addr;
    for (int i = 1; i < RLAT; i++) ap[i] <= ap[i-1];
  end

  assign mem_rdata = mem_arr[ap[RLAT-1]] ^ cmask[ap[RLAT-1]];

  // ---------------------------------------------------------------------------
  // One complete transaction with timing and value checks against the
  // transaction-level reference (ref_mem + latency formulas). Starts and ends
  // at a falling edge with the DUT idle.
  // ---------------------------------------------------------------------------
  task automatic run_txn(input bit wr, input logic [7:0] a, input logic [7:0] d,
                         input int bp);
    int lat, c0;
    bit acc;
    logic [7:0] er;
    logic ee;
    lat = wr ? (VERIFY ? RLAT + 3 : 2) : RLAT + 2;
    er  = wr ? (VERIFY ? (d ^ cmask[a]) : 8'h00) : (ref_mem[a] ^ cmask[a]);
    ee  = VERIFY && wr && (cmask[a] != 8'h00);

    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d; rsp_ready = 1'b0;
    acc = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (req_ready) begin acc = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept: req_ready=%b required 1 within 20 cycles", req_ready);
      req_valid = 1'b0;
      return;
    end
    c0 = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    if (wr) ref_mem[a] = d;

    for (int k = 1; k < lat; k++) begin
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || mem_wr_en !== (wr && k == 1) ||
          mem_addr !== a || (wr && k == 1 && mem_wdata !== d)) begin
        errors++;
        $display("FAIL busy C+%0d: valid=%b ready=%b wr_en=%b addr=%h wdata=%h required valid=0 ready=0 wr_en=%b addr=%h wdata=%h",
                 k, rsp_valid, req_ready, mem_wr_en, mem_addr, mem_wdata, wr && k == 1, a, d);
      end
      req_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    req_valid = 1'b0;

    checks++;
    if (cyc != c0 + lat || rsp_valid !== 1'b1 || rsp_rdata !== er || rsp_err !== ee ||
        mem_wr_en !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL resp C+%0d: valid=%b rdata=%h err=%b wr_en=%b ready=%b required valid=1 rdata=%h err=%b wr_en=0 ready=0",
               cyc - c0, rsp_valid, rsp_rdata, rsp_err, mem_wr_en, req_ready, er, ee);
    end

    for (int k = 0; k < bp; k++) begin
      req_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== er || rsp_err !== ee || req_ready !== 1'b0 ||
          mem_wr_en !== 1'b0 || mem_addr !== a) begin
        errors++;
        $display("FAIL stall %0d: valid=%b rdata=%h err=%b ready=%b wr_en=%b addr=%h required 1 %h %b 0 0 %h",
                 k, rsp_valid, rsp_rdata, rsp_err, req_ready, mem_wr_en, mem_addr, er, ee, a);
      end
    end

    // Handshake, possibly with a simultaneous req_valid that must be ignored.
    rsp_ready = 1'b1;
    req_valid = 1'($urandom_range(0, 1));
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_wr_en !== 1'b0 || txn_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL done: valid=%b ready=%b wr_en=%b txn_cnt=%h required 0 1 0 %h",
               rsp_valid, req_ready, mem_wr_en, txn_cnt, exp_cnt);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    mem_init = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 8'h00 || rsp_err !== 1'b0 ||
        txn_cnt !== 16'h0 || mem_wr_en !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_vals: ready=%b valid=%b rdata=%h err=%b cnt=%h wr_en=%b addr=%h wdata=%h required all 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err, txn_cnt, mem_wr_en, mem_addr, mem_wdata);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_write;
    run_txn(1'b1, 8'h02, 8'hA5, 0);
  endtask

  task automatic test_read;
    run_txn(1'b0, 8'h02, 8'h00, 0);
  endtask

  task automatic test_backpressure;
    run_txn(1'b0, 8'h02, 8'h00, 5);
    run_txn(1'b1, 8'h40, 8'h3C, 5);
  endtask

  task automatic test_verify;
    cmask[8'h10] = 8'hFF;
    run_txn(1'b1, 8'h10, 8'hA5, 0);
    cmask[8'h10] = 8'h00;
    run_txn(1'b1, 8'h11, 8'hA5, 2);
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)),
              8'($urandom), $urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_mid;
    bit acc;
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'h33; req_wdata = 8'h77;
    acc = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (req_ready) begin acc = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (!acc || mem_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL mid_write: accepted=%b wr_en=%b required 1 1", acc, mem_wr_en);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (mem_wr_en !== 1'b0 || rsp_valid !== 1'b0 || txn_cnt !== 16'h0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: wr_en=%b valid=%b cnt=%h ready=%b required 0 0 0000 0",
               mem_wr_en, rsp_valid, txn_cnt, req_ready);
    end
    exp_cnt = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: ready=%b valid=%b required 1 0", req_ready, rsp_valid);
    end
    // The dropped write never reached memory: ref_mem[0x33] is unchanged.
    run_txn(1'b0, 8'h33, 8'h00, 0);
  endtask

  task automatic test_wrap;
    force dut.txn_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.txn_cnt;
    @(negedge clk);
    exp_cnt = 16'hFFFF;
    checks++;
    if (txn_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL preload: txn_cnt=%h required ffff", txn_cnt);
    end
    run_txn(1'b1, 8'h55, 8'h12, 0);   // done check expects 0000
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'($urandom);
      cmask[i]   = 8'h00;
    end
    ref_mem[8'h02] = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    if (VERIFY) test_verify();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
